// File: rtl/add16_arbiter.sv
// Two-port arbiter sharing a single 16-bit adder: grant, latch operands,
// add, register the sum and pulse a per-port done.

module add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);
    // Unsigned add; carry is dropped so the sum wraps mod 2^16.
    assign sum = a + b;
endmodule

module add16_arbiter #(
    parameter bit FAIR      = 1'b1,
    parameter bit RESET_PTR = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic        req1,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        grant0,
    output logic        grant1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] result,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t      state;
    logic        owner;
    logic        ptr;
    logic        pick;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] sum;

    add16 u_add16 (
        .a   (op_a),
        .b   (op_b),
        .sum (sum)
    );

    // Winner among pending requests; only consulted in IDLE.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = FAIR ? ptr : 1'b0;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= 1'b0;
            ptr    <= RESET_PTR;
            op_a   <= 16'h0000;
            op_b   <= 16'h0000;
            grant0 <= 1'b0;
            grant1 <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            result <= 16'h0000;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner  <= pick;
                        op_a   <= pick ? a1 : a0;
                        op_b   <= pick ? b1 : b0;
                        grant0 <= ~pick;
                        grant1 <= pick;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    result <= sum;
                    done0  <= ~owner;
                    done1  <= owner;
                    state  <= DONE;
                end
                DONE: begin
                    // Requests seen on this edge are deliberately ignored.
                    done0  <= 1'b0;
                    done1  <= 1'b0;
                    grant0 <= 1'b0;
                    grant1 <= 1'b0;
                    busy   <= 1'b0;
                    if (FAIR) begin
                        ptr <= ~owner;
                    end
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add16_arbiter.sv
// Randomized bench for add16_arbiter: transaction-level model of arbitration
// and wrapping addition, plus a fixed-priority instance.

module tb_add16_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic        grant0, grant1, done0, done1, busy;
    logic [15:0] result;

    logic        fr0, fr1;
    logic [15:0] fa0, fb0, fa1, fb1;
    logic        fgrant0, fgrant1, fdone0, fdone1, fbusy;
    logic [15:0] fresult;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cyc = 0;
    bit mptr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add16_arbiter #(.FAIR(1'b1), .RESET_PTR(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
        .result(result), .busy(busy)
    );

    add16_arbiter #(.FAIR(1'b0), .RESET_PTR(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .req0(fr0), .a0(fa0), .b0(fb0),
        .req1(fr1), .a1(fa1), .b1(fb1),
        .grant0(fgrant0), .grant1(fgrant1), .done0(fdone0), .done1(fdone1),
        .result(fresult), .busy(fbusy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_add(input logic [15:0] x, input logic [15:0] y);
        return 16'((int'(x) + int'(y)) % 65536);
    endfunction

    // Grant/done exclusivity and done-implies-grant, on both instances.
    always @(negedge clk) begin
        if (!reset) begin
            chk("excl", 32'((grant0 & grant1) | (done0 & done1) | (done0 & ~grant0) | (done1 & ~grant1)), 0);
            chk("fp_excl", 32'((fgrant0 & fgrant1) | (fdone0 & fdone1) | (fdone0 & ~fgrant0) | (fdone1 & ~fgrant1)), 0);
        end
    end

    // One transaction on the fair instance, starting at a negedge in IDLE.
    task automatic do_op(input bit r0, input bit r1,
                         input logic [15:0] x0, input logic [15:0] y0,
                         input logic [15:0] x1, input logic [15:0] y1);
        bit          w;
        logic [15:0] exp_sum;
        w = (r0 && r1) ? mptr : r1;
        exp_sum = w ? model_add(x1, y1) : model_add(x0, y0);
        req0 = r0; req1 = r1;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        @(negedge clk);
        chk("grant_win", 32'(w ? grant1 : grant0), 1);
        chk("grant_lose", 32'(w ? grant0 : grant1), 0);
        chk("busy_exec", 32'(busy), 1);
        chk("done_early", 32'(done0 | done1), 0);
        // Operands were latched at grant, so the winner may change them now.
        if (w) begin a1 = 16'($urandom); b1 = 16'($urandom); end
        else   begin a0 = 16'($urandom); b0 = 16'($urandom); end
        @(negedge clk);
        chk("done_win", 32'(w ? done1 : done0), 1);
        chk("done_lose", 32'(w ? done0 : done1), 0);
        chk("grant_hold", 32'(w ? grant1 : grant0), 1);
        chk("busy_done", 32'(busy), 1);
        chk("result", 32'(result), 32'(exp_sum));
        done_cyc = cyc;
        if (w) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
        chk("idle", 32'({busy, grant0, grant1, done0, done1}), 0);
        chk("result_hold", 32'(result), 32'(exp_sum));
        mptr = ~w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit          p0, p1, n0, n1, won;
        logic [15:0] oa [2];
        logic [15:0] ob [2];
        logic [15:0] fa, fb;
        int          prev, cnt0, cnt1;

        reset = 1'b1;
        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        fr0 = 0; fr1 = 0; fa0 = 0; fb0 = 0; fa1 = 0; fb1 = 0;
        mptr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'({grant0, grant1, done0, done1, busy}), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_fp_state", 32'({fgrant0, fgrant1, fdone0, fdone1, fbusy}), 0);
        reset = 1'b0;
        @(negedge clk);

        do_op(1, 0, 16'hffff, 16'h0000, 16'h1234, 16'h1111);
        do_op(0, 1, 16'h0000, 16'h0000, 16'h0001, 16'hffff);
        do_op(0, 1, 16'h0000, 16'h0000, 16'h0000, 16'hffff);

        // Both ports requesting from reset: 0, 1, 0 with 3-cycle done spacing.
        reset = 1'b1;
        req0 = 1; req1 = 1;
        @(negedge clk);
        reset = 1'b0;
        mptr = 1'b0;
        do_op(1, 1, 16'h0010, 16'h0020, 16'h0100, 16'h0200);
        prev = done_cyc;
        do_op(1, 1, 16'h0011, 16'h0022, 16'h0100, 16'h0200);
        chk("spacing_1", 32'(done_cyc - prev), 3);
        prev = done_cyc;
        do_op(1, 1, 16'h0011, 16'h0022, 16'h0101, 16'h0202);
        chk("spacing_2", 32'(done_cyc - prev), 3);
        req1 = 0;
        @(negedge clk);
        mptr = 1'b0;

        // Fibonacci through port 1; model result checked at each done1.
        fa = 16'd0; fb = 16'd1;
        for (int i = 0; i < 16; i++) begin
            do_op(0, 1, 16'h0, 16'h0, fa, fb);
            chk("fib", 32'(result), 32'(int'(fa) + int'(fb)));
            {fa, fb} = {fb, model_add(fa, fb)};
        end
        chk("fib_last", 32'(result), 1597);

        // Random traffic; a loser keeps its request and operands.
        p0 = 0; p1 = 0;
        for (int i = 0; i < 40; i++) begin
            n0 = p0 | bit'($urandom_range(0, 1));
            n1 = p1 | bit'($urandom_range(0, 1));
            if (!n0 && !n1) n0 = 1'b1;
            if (n0 && !p0) begin oa[0] = 16'($urandom); ob[0] = 16'($urandom); end
            if (n1 && !p1) begin oa[1] = 16'($urandom); ob[1] = 16'($urandom); end
            do_op(n0, n1, oa[0], ob[0], oa[1], ob[1]);
            won = ~mptr;
            p0 = n0 && won;
            p1 = n1 && !won;
        end
        req0 = 0; req1 = 0;
        @(negedge clk);

        // Fixed priority: port 0 starves port 1 while held.
        fr0 = 1; fr1 = 1; fa0 = 16'd3; fb0 = 16'd4; fa1 = 16'd10; fb1 = 16'd20;
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fdone0) begin
                cnt0++;
                chk("fp_result0", 32'(fresult), 7);
            end
            if (fdone1) cnt1++;
            if (fgrant1) chk("fp_starve_grant1", 32'(fgrant1), 0);
        end
        chk("fp_cnt0", 32'(cnt0), 4);
        chk("fp_cnt1", 32'(cnt1), 0);
        fr0 = 0;
        @(negedge clk);
        chk("fp_grant1", 32'(fgrant1), 1);
        chk("fp_grant0", 32'(fgrant0), 0);
        @(negedge clk);
        chk("fp_done1", 32'(fdone1), 1);
        chk("fp_result1", 32'(fresult), 30);
        fr1 = 0;
        @(negedge clk);
        chk("fp_idle", 32'({fbusy, fgrant0, fgrant1, fdone0, fdone1}), 0);

        // Reset during EXEC discards the operation.
        req0 = 1; a0 = 16'd5; b0 = 16'd6;
        @(negedge clk);
        chk("pre_rst_grant", 32'(grant0), 1);
        reset = 1'b1;
        req0 = 0;
        #1;
        chk("mid_rst_outs", 32'({grant0, grant1, done0, done1, busy}), 0);
        chk("mid_rst_result", 32'(result), 0);
        @(negedge clk);
        reset = 1'b0;
        mptr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'({grant0, grant1, done0, done1, busy}), 0);
        end
        do_op(1, 1, 16'h8000, 16'h8001, 16'h00ff, 16'h0001);
        req1 = 0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
